// File: rtl/display_arbiter_if.sv
// -----------------------------------------------------------------------------
// display_arbiter_if
//
// Purpose: groups the source inputs and display outputs of display_arbiter so
// the arbiter and its environment share one bundle.
//
// Signals:
//   mode_toggle        single-cycle pulse, user clock/timer switch request
//   alarm              single-cycle pulse, alarm event
//   clk_num0/1, clk_dot  clock source digit pairs and dot
//   tmr_num0/1, tmr_dot  timer source digit pairs and dot
//   host_req           level, host display request
//   host_num0/1        host digit pairs
//   host_grant         high while the host owns the display
//   num0/1, dot        selected digit pairs and dot
//   sel                owner code: 0 CLOCK, 1 TIMER, 2 HOST, 3 ALARM
//   blank              high means the display driver suppresses all segments
//
// Modports:
//   master  environment side (drives sources, observes the display)
//   slave   arbiter side
//
// Handshake: there is no valid/ready pair here. mode_toggle and alarm are
// single-cycle event pulses sampled on every rising clock edge; host_req is a
// level that is sampled on every edge and answered by host_grant one cycle
// later.
// -----------------------------------------------------------------------------
interface display_arbiter_if;
    logic       mode_toggle;
    logic       alarm;
    logic [5:0] clk_num0;
    logic [5:0] clk_num1;
    logic       clk_dot;
    logic [5:0] tmr_num0;
    logic [5:0] tmr_num1;
    logic       tmr_dot;
    logic       host_req;
    logic [5:0] host_num0;
    logic [5:0] host_num1;
    logic       host_grant;
    logic [5:0] num0;
    logic [5:0] num1;
    logic       dot;
    logic [1:0] sel;
    logic       blank;

    modport master (
        output mode_toggle, alarm,
        output clk_num0, clk_num1, clk_dot,
        output tmr_num0, tmr_num1, tmr_dot,
        output host_req, host_num0, host_num1,
        input  host_grant, num0, num1, dot, sel, blank
    );

    modport slave (
        input  mode_toggle, alarm,
        input  clk_num0, clk_num1, clk_dot,
        input  tmr_num0, tmr_num1, tmr_dot,
        input  host_req, host_num0, host_num1,
        output host_grant, num0, num1, dot, sel, blank
    );
endinterface

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//
// Purpose: decides which source (clock, timer, host or alarm) owns a two-pair
// digit display and registers the selected digits, dot, owner code, blanking
// and host grant.
//
// Parameters:
//   TICK_DIV     clock cycles per tick
//   BLINK_TICKS  ticks per blink half-period during an alarm
//   ALARM_TICKS  alarm display duration in ticks
//
// Ports:
//   clock  system clock, all logic on the rising edge
//   reset  asynchronous, active-high reset
//   bus    display_arbiter_if.slave (sources in, display out)
//
// Build option:
//   DISPLAY_ARBITER_ALARM_EN  when defined, the ALARM owner with its tick
//   prescaler, blink counter and duration counter is built. When undefined,
//   the alarm pulse is ignored, sel never reaches 3 and blank stays 0.
//
// Priority when choosing the owner: ALARM > HOST > user_mode (CLOCK/TIMER).
// The owner register doubles as the sel output, so sel is also the debug view
// of the FSM state.
// -----------------------------------------------------------------------------
module display_arbiter #(
    parameter int TICK_DIV    = 50000,
    parameter int BLINK_TICKS = 250,
    parameter int ALARM_TICKS = 30000
) (
    input  logic               clock,
    input  logic               reset,
    display_arbiter_if.slave   bus
);

    localparam logic [1:0] S_CLOCK = 2'd0;
    localparam logic [1:0] S_TIMER = 2'd1;
    localparam logic [1:0] S_HOST  = 2'd2;
    localparam logic [1:0] S_ALARM = 2'd3;

    logic [1:0] state_q, state_d;
    // 0 = CLOCK, 1 = TIMER; same encoding as the matching state codes
    logic       user_mode_q, user_mode_d;
    logic [1:0] user_state;

    logic [5:0] num0_q, num0_d;
    logic [5:0] num1_q, num1_d;
    logic       dot_q, dot_d;
    logic       host_grant_q, host_grant_d;
    logic       blank_q, blank_d;

    assign user_state = {1'b0, user_mode_q};

`ifdef DISPLAY_ARBITER_ALARM_EN
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int DUR_W   = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic               tick;
    logic               exit_alarm;

    // Free-running prescaler; tick is high for one cycle out of TICK_DIV.
    assign tick    = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PRESC_W'(1);
`endif

    // Owner selection.
    always_comb begin
        state_d     = state_q;
        user_mode_d = user_mode_q;
`ifdef DISPLAY_ARBITER_ALARM_EN
        dur_d       = dur_q;
        exit_alarm  = 1'b0;
        // An alarm pulse always wins: it enters ALARM (or just reloads the
        // duration when already there) and swallows a coincident toggle.
        if (bus.alarm) begin
            state_d = S_ALARM;
            dur_d   = DUR_W'(ALARM_TICKS);
        end else
`endif
        begin
            case (state_q)
                S_CLOCK, S_TIMER: begin
                    if (bus.mode_toggle) begin
                        user_mode_d = ~user_mode_q;
                    end
                    state_d = bus.host_req ? S_HOST : {1'b0, user_mode_d};
                end
                S_HOST: begin
                    // mode_toggle is deliberately not looked at here.
                    if (!bus.host_req) begin
                        state_d = user_state;
                    end
                end
`ifdef DISPLAY_ARBITER_ALARM_EN
                S_ALARM: begin
                    if (tick) begin
                        // Leave on the tick that brings the count to zero.
                        if (dur_q <= DUR_W'(1)) begin
                            exit_alarm = 1'b1;
                        end else begin
                            dur_d = dur_q - DUR_W'(1);
                        end
                    end
                    // A toggle here is an acknowledge, not a mode change.
                    if (bus.mode_toggle) begin
                        exit_alarm = 1'b1;
                    end
                    if (exit_alarm) begin
                        state_d = bus.host_req ? S_HOST : user_state;
                    end
                end
`endif
                default: state_d = S_CLOCK;
            endcase
        end
    end

    // Blink phase; blank_q itself is the phase bit since it is only non-zero
    // while the alarm owns the display.
    always_comb begin
        blank_d = 1'b0;
`ifdef DISPLAY_ARBITER_ALARM_EN
        blink_cnt_d = blink_cnt_q;
        if (state_d != S_ALARM) begin
            blink_cnt_d = '0;
            blank_d     = 1'b0;
        end else if (state_q != S_ALARM) begin
            // Fresh entry starts blanked.
            blink_cnt_d = '0;
            blank_d     = 1'b1;
        end else begin
            blank_d = blank_q;
            if (tick) begin
                if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
                    blink_cnt_d = '0;
                    blank_d     = ~blank_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end
        end
`endif
    end

    // Output selection from the next owner, so the registered outputs carry
    // the owner and source values of the cycle just sampled.
    always_comb begin
        num0_d       = bus.clk_num0;
        num1_d       = bus.clk_num1;
        dot_d        = bus.clk_dot;
        host_grant_d = 1'b0;
        case (state_d)
            S_TIMER: begin
                num0_d = bus.tmr_num0;
                num1_d = bus.tmr_num1;
                dot_d  = bus.tmr_dot;
            end
            S_HOST: begin
                num0_d       = bus.host_num0;
                num1_d       = bus.host_num1;
                dot_d        = 1'b0;
                host_grant_d = 1'b1;
            end
            default: begin
                // CLOCK and ALARM both show the clock source.
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_CLOCK;
            user_mode_q  <= 1'b0;
            num0_q       <= '0;
            num1_q       <= '0;
            dot_q        <= 1'b0;
            host_grant_q <= 1'b0;
            blank_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            user_mode_q  <= user_mode_d;
            num0_q       <= num0_d;
            num1_q       <= num1_d;
            dot_q        <= dot_d;
            host_grant_q <= host_grant_d;
            blank_q      <= blank_d;
        end
    end

`ifdef DISPLAY_ARBITER_ALARM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            blink_cnt_q <= '0;
            dur_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            dur_q       <= dur_d;
        end
    end
`endif

    assign bus.num0       = num0_q;
    assign bus.num1       = num1_q;
    assign bus.dot        = dot_q;
    assign bus.sel        = state_q;
    assign bus.blank      = blank_q;
    assign bus.host_grant = host_grant_q;

endmodule

// File: tb/tb_display_arbiter.sv
module tb_display_arbiter;

    localparam int TD = 4;
    localparam int BT = 2;
    localparam int AT = 10;

    localparam logic [1:0] S_CLOCK = 2'd0;
    localparam logic [1:0] S_TIMER = 2'd1;
    localparam logic [1:0] S_HOST  = 2'd2;
    localparam logic [1:0] S_ALARM = 2'd3;

`ifdef DISPLAY_ARBITER_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    display_arbiter_if bus();

    display_arbiter #(
        .TICK_DIV    (TD),
        .BLINK_TICKS (BT),
        .ALARM_TICKS (AT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    // packed as {num0, num1, dot, sel, blank, host_grant}
    logic [16:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [1:0] m_state;
    logic       m_user;
    int         m_cyc;
    int         m_since_entry;
    int         m_since_reload;

    function automatic logic [16:0] observed();
        return {bus.num0, bus.num1, bus.dot, bus.sel, bus.blank, bus.host_grant};
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state        = S_CLOCK;
        m_user         = 1'b0;
        m_cyc          = 0;
        m_since_entry  = 0;
        m_since_reload = 0;
        exp_q.delete();
    endtask

    // Advances the model by one rising edge using the inputs now on the bus
    // and returns the outputs expected right after that edge.
    task automatic model_edge(output logic [16:0] e);
        bit         tick;
        logic [1:0] nxt;
        logic [5:0] n0, n1;
        logic       d;
        logic       bl;
        tick = (m_cyc % TD) == TD - 1;
        m_cyc++;
        nxt = m_state;
        if (ALARM_EN && bus.alarm) begin
            if (m_state == S_ALARM) begin
                if (tick) m_since_entry++;
            end else begin
                m_since_entry = 0;
            end
            m_since_reload = 0;
            nxt = S_ALARM;
        end else begin
            case (m_state)
                S_CLOCK, S_TIMER: begin
                    if (bus.mode_toggle) m_user = ~m_user;
                    nxt = bus.host_req ? S_HOST : {1'b0, m_user};
                end
                S_HOST: begin
                    if (!bus.host_req) nxt = {1'b0, m_user};
                end
                default: begin
                    if (tick) begin
                        m_since_entry++;
                        m_since_reload++;
                    end
                    if (bus.mode_toggle || (m_since_reload >= AT))
                        nxt = bus.host_req ? S_HOST : {1'b0, m_user};
                end
            endcase
        end
        m_state = nxt;
        case (nxt)
            S_TIMER: begin n0 = bus.tmr_num0;  n1 = bus.tmr_num1;  d = bus.tmr_dot; end
            S_HOST:  begin n0 = bus.host_num0; n1 = bus.host_num1; d = 1'b0;        end
            default: begin n0 = bus.clk_num0;  n1 = bus.clk_num1;  d = bus.clk_dot; end
        endcase
        bl = (nxt == S_ALARM) && (((m_since_entry / BT) % 2) == 0);
        e = {n0, n1, d, nxt, bl, (nxt == S_HOST)};
    endtask

    // ---------------- driver ----------------
    task automatic step();
        logic [16:0] e;
        model_edge(e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        check("cycle", observed(), exp_q.pop_front());
        bus.mode_toggle = 1'b0;
        bus.alarm       = 1'b0;
    endtask

    task automatic randomize_digits();
        bus.clk_num0  = 6'($urandom_range(0, 63));
        bus.clk_num1  = 6'($urandom_range(0, 63));
        bus.clk_dot   = 1'($urandom_range(0, 1));
        bus.tmr_num0  = 6'($urandom_range(0, 63));
        bus.tmr_num1  = 6'($urandom_range(0, 63));
        bus.tmr_dot   = 1'($urandom_range(0, 1));
        bus.host_num0 = 6'($urandom_range(0, 63));
        bus.host_num1 = 6'($urandom_range(0, 63));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.mode_toggle = 1'b0;
        bus.alarm       = 1'b0;
        bus.clk_num0    = '0;
        bus.clk_num1    = '0;
        bus.clk_dot     = 1'b0;
        bus.tmr_num0    = '0;
        bus.tmr_num1    = '0;
        bus.tmr_dot     = 1'b0;
        bus.host_req    = 1'b0;
        bus.host_num0   = '0;
        bus.host_num1   = '0;
        model_reset();

        // outputs held at zero while reset is high
        #12;
        check("reset_hold", observed(), 17'd0);

        // reset release, clock source shown after one cycle
        bus.clk_num0 = 6'd12;
        bus.clk_num1 = 6'd34;
        #10;
        reset = 1'b0;
        step();
        check("rel_num0", 17'(bus.num0), 17'd12);
        check("rel_num1", 17'(bus.num1), 17'd34);
        check("rel_sel", 17'(bus.sel), 17'(S_CLOCK));
        check("rel_blank_grant", 17'({bus.blank, bus.host_grant}), 17'd0);

        // user toggle CLOCK -> TIMER -> CLOCK
        bus.tmr_num0    = 6'd5;
        bus.mode_toggle = 1'b1;
        step();
        check("tog1_sel", 17'(bus.sel), 17'(S_TIMER));
        check("tog1_num0", 17'(bus.num0), 17'd5);
        bus.mode_toggle = 1'b1;
        step();
        check("tog2_sel", 17'(bus.sel), 17'(S_CLOCK));

        // host ownership from TIMER, toggle dropped while in HOST
        bus.mode_toggle = 1'b1;
        step();
        bus.host_req  = 1'b1;
        bus.host_num0 = 6'd7;
        step();
        check("host_sel", 17'(bus.sel), 17'(S_HOST));
        check("host_grant", 17'(bus.host_grant), 17'd1);
        check("host_num0", 17'(bus.num0), 17'd7);
        bus.mode_toggle = 1'b1;
        step();
        check("host_tog_sel", 17'(bus.sel), 17'(S_HOST));
        bus.host_req = 1'b0;
        step();
        check("host_rel_sel", 17'(bus.sel), 17'(S_TIMER));
        check("host_rel_grant", 17'(bus.host_grant), 17'd0);

        // alarm entered on a tick edge so blink/duration land on exact clocks
        while ((m_cyc % TD) != TD - 1) step();
        bus.clk_num0 = 6'd21;
        bus.alarm    = 1'b1;
        step();
`ifdef DISPLAY_ARBITER_ALARM_EN
        check("alarm_sel", 17'(bus.sel), 17'(S_ALARM));
        check("alarm_num0", 17'(bus.num0), 17'd21);
        check("alarm_blank0", 17'(bus.blank), 17'd1);
`else
        check("noalarm_sel", 17'(bus.sel), 17'(S_TIMER));
        check("noalarm_blank", 17'(bus.blank), 17'd0);
`endif
        for (int k = 1; k <= 40; k++) begin
            randomize_digits();
            step();
`ifdef DISPLAY_ARBITER_ALARM_EN
            if (k == 7)  check("blink_k7", 17'(bus.blank), 17'd1);
            if (k == 8)  check("blink_k8", 17'(bus.blank), 17'd0);
            if (k == 16) check("blink_k16", 17'(bus.blank), 17'd1);
            if (k == 39) check("dur_k39", 17'(bus.sel), 17'(S_ALARM));
`endif
            if (k == 40) check("dur_k40", 17'(bus.sel), 17'(S_TIMER));
        end

        // alarm with toggle while host holds the display
        bus.host_req = 1'b1;
        step();
        bus.alarm       = 1'b1;
        bus.mode_toggle = 1'b1;
        step();
`ifdef DISPLAY_ARBITER_ALARM_EN
        check("al_tog_sel", 17'(bus.sel), 17'(S_ALARM));
`else
        check("al_tog_sel", 17'(bus.sel), 17'(S_HOST));
`endif
        for (int k = 0; k < 3; k++) step();
        bus.mode_toggle = 1'b1;
        step();
        check("ack_sel", 17'(bus.sel), 17'(S_HOST));
        bus.host_req = 1'b0;
        step();
        check("ack_user", 17'(bus.sel), 17'(S_TIMER));

        // reload while in alarm extends the duration
        bus.alarm = 1'b1;
        step();
        for (int k = 0; k < 20; k++) step();
        bus.alarm = 1'b1;
        step();
        for (int k = 0; k < 30; k++) step();
`ifdef DISPLAY_ARBITER_ALARM_EN
        check("reload_sel", 17'(bus.sel), 17'(S_ALARM));
`else
        check("reload_sel", 17'(bus.sel), 17'(S_TIMER));
`endif

        // reset in the middle of an alarm
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("mid_rst_now", observed(), 17'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("mid_rst_hold", observed(), 17'd0);
        @(negedge clock);
        reset = 1'b0;
        step();
        check("post_rst_sel", 17'(bus.sel), 17'(S_CLOCK));
        for (int k = 0; k < 50; k++) begin
            randomize_digits();
            step();
        end
        check("no_resume", 17'({bus.sel, bus.blank}), 17'd0);

        // random traffic, checked cycle by cycle against the model
        for (int k = 0; k < 400; k++) begin
            randomize_digits();
            bus.mode_toggle = ($urandom_range(0, 7) == 0);
            bus.alarm       = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) bus.host_req = ~bus.host_req;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
